// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences one access at a time into a read-first mixed-signal SRAM macro
// over valid/ready request and response channels, thresholding the real-valued read data.
module sram_access_ctrl #(
   parameter int  DATA_WIDTH = 8,
   parameter int  ADDR_WIDTH = 4,
   parameter real VDD        = 1.8,
   parameter real VTH        = 0.9,
   parameter int  STROBE_CYC = 1,
   parameter int  WAIT_CYC   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_we_o,
   output logic                  busy_o,
   output real                   sram_clk_o,
   output real                   sram_we_o,
   output real                   sram_addr_o [ADDR_WIDTH],
   output real                   sram_din_o  [DATA_WIDTH],
   input  real                   sram_dout_i [DATA_WIDTH]
);

   if (STROBE_CYC < 1 || WAIT_CYC < 1) begin : g_bad_param
      $error("sram_access_ctrl: STROBE_CYC and WAIT_CYC must be at least 1");
   end

   localparam int CW = $clog2((STROBE_CYC > WAIT_CYC ? STROBE_CYC : WAIT_CYC) + 1);
   localparam logic [CW-1:0] S_LAST = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] W_LAST = CW'(WAIT_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rsp_we_q, rsp_we_d;
   logic [DATA_WIDTH-1:0] dout_bits;
   logic                  drive;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rsp_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rsp_we_q <= rsp_we_d;
      end
   end

   always_comb begin
      for (int k = 0; k < DATA_WIDTH; k++) dout_bits[k] = sram_dout_i[k] > VTH;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rsp_we_d = rsp_we_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            state_d = SETUP;
            we_d    = req_we_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = '0;
         end
         STROBE: begin
            state_d = (cnt_q == S_LAST) ? WAIT : STROBE;
            cnt_d   = (cnt_q == S_LAST) ? '0 : cnt_q + CW'(1);
         end
         WAIT: if (cnt_q == W_LAST) begin
            state_d  = RESP;
            rdata_d  = dout_bits;
            rsp_we_d = we_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         RESP: state_d = rsp_ready_i ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   // Pins stay driven through WAIT so the macro's delayed write sees stable data.
   assign drive       = (state_q == SETUP) || (state_q == STROBE) || (state_q == WAIT);
   assign req_ready_o = state_q == IDLE;
   assign busy_o      = state_q != IDLE;
   assign rsp_valid_o = state_q == RESP;
   assign rsp_rdata_o = rdata_q;
   assign rsp_we_o    = rsp_we_q;
   assign sram_clk_o  = (state_q == STROBE) ? VDD : 0.0;
   assign sram_we_o   = (drive && we_q) ? VDD : 0.0;

   for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_addr
      assign sram_addr_o[i] = (drive && addr_q[i]) ? VDD : 0.0;
   end

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_din
      assign sram_din_o[i] = (drive && wdata_q[i]) ? VDD : 0.0;
   end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed bench for sram_access_ctrl with a behavioural read-first macro
// (delayed write) on the default instance and a fixed-data second instance with longer timing.
module tb_sram_access_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [3:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       rsp_valid, rsp_ready = 1'b0, rsp_we, busy;
   logic [7:0] rsp_rdata;
   real        sram_clk, sram_we;
   real        sram_addr [4];
   real        sram_din [8];
   real        sram_dout [8];
   real        model_dout [8];
   real        ovr_dout [8];
   logic       ovr = 1'b0;

   logic       v2 = 1'b0, rdy2, we2 = 1'b0, rv2, rr2 = 1'b0, rwe2, busy2;
   logic [3:0] a2 = '0;
   logic [7:0] d2 = '0, rd2;
   real        sclk2, swe2;
   real        saddr2 [4];
   real        sdin2 [8];
   real        sdout2 [8];

   logic [7:0] din_b, din2_b, mem_wr;
   logic [3:0] addr_b;
   logic       sclk_b, we_b, sclk_prev = 1'b0;
   logic [7:0] mem [16] = '{default: '0};
   int         pend = 0;
   int         total = 0, bad = 0;

   always #5 clk = ~clk;

   sram_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_we_o(rsp_we), .busy_o(busy),
      .sram_clk_o(sram_clk), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_din_o(sram_din), .sram_dout_i(sram_dout)
   );

   sram_access_ctrl #(.STROBE_CYC(2), .WAIT_CYC(3)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(v2), .req_ready_o(rdy2), .req_we_i(we2),
      .req_addr_i(a2), .req_wdata_i(d2),
      .rsp_valid_o(rv2), .rsp_ready_i(rr2), .rsp_rdata_o(rd2),
      .rsp_we_o(rwe2), .busy_o(busy2),
      .sram_clk_o(sclk2), .sram_we_o(swe2), .sram_addr_o(saddr2),
      .sram_din_o(sdin2), .sram_dout_i(sdout2)
   );

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         din_b[i]     = sram_din[i] > 0.9;
         din2_b[i]    = sdin2[i] > 0.9;
         sram_dout[i] = ovr ? ovr_dout[i] : model_dout[i];
      end
      for (int i = 0; i < 4; i++) addr_b[i] = sram_addr[i] > 0.9;
      sclk_b = sram_clk > 0.9;
      we_b   = sram_we > 0.9;
   end

   // Read-first macro: old word appears on strobe rise, write lands two cycles later.
   always @(negedge clk) begin
      if (sclk_b && !sclk_prev) begin
         mem_wr = mem[addr_b];
         for (int i = 0; i < 8; i++) model_dout[i] <= mem_wr[i] ? 1.8 : 0.0;
         if (we_b) pend <= 2;
      end else if (pend > 0) begin
         pend <= pend - 1;
         if (pend == 1 && we_b) mem[addr_b] <= din_b;
      end
      sclk_prev <= sclk_b;
   end

   task automatic access(input logic we, input logic [3:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output logic rw, output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      rd = rsp_rdata; rw = rsp_we;
      @(posedge clk);
   endtask

   task automatic test_reset;
      #2;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=00", rsp_rdata); end
      total++; if (rsp_we !== 1'b0) begin bad++; $display("FAIL reset_rsp_we got=%b exp=0", rsp_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (sram_clk != 0.0 || sram_we != 0.0) begin bad++; $display("FAIL reset_sram_clk_we got=%f/%f exp=0.0", sram_clk, sram_we); end
      total++; if (din_b !== 8'h00 || addr_b !== 4'h0) begin bad++; $display("FAIL reset_sram_din_addr got=%h/%h exp=00/0", din_b, addr_b); end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read;
      logic [7:0] rd; logic rw; int lat;
      access(1'b1, 4'h3, 8'hA5, rd, rw, lat);
      total++; if (rd !== 8'h00) begin bad++; $display("FAIL wr1_rdata got=%h exp=00", rd); end
      total++; if (rw !== 1'b1) begin bad++; $display("FAIL wr1_we got=%b exp=1", rw); end
      total++; if (lat != 4) begin bad++; $display("FAIL wr1_latency got=%0d exp=4", lat); end
      access(1'b0, 4'h3, 8'h00, rd, rw, lat);
      total++; if (rd !== 8'hA5) begin bad++; $display("FAIL rd1_rdata got=%h exp=a5", rd); end
      total++; if (rw !== 1'b0) begin bad++; $display("FAIL rd1_we got=%b exp=0", rw); end
      total++; if (lat != 4) begin bad++; $display("FAIL rd1_latency got=%0d exp=4", lat); end
   endtask

   task automatic test_read_first;
      logic [7:0] rd; logic rw; int lat;
      access(1'b1, 4'h3, 8'h5A, rd, rw, lat);
      total++; if (rd !== 8'hA5) begin bad++; $display("FAIL wr2_rdata got=%h exp=a5", rd); end
      access(1'b0, 4'h3, 8'h00, rd, rw, lat);
      total++; if (rd !== 8'h5A) begin bad++; $display("FAIL rd2_rdata got=%h exp=5a", rd); end
      access(1'b0, 4'hC, 8'hFF, rd, rw, lat);
      total++; if (rd !== 8'h00) begin bad++; $display("FAIL rd_other_rdata got=%h exp=00", rd); end
   endtask

   task automatic test_back_pressure;
      int n;
      logic held_ok;
      logic [7:0] rd; logic rw;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h5; req_wdata = 8'h77; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_we = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      total++; if (n != 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", n); end
      held_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_we !== 1'b1 || req_ready !== 1'b0)
            held_ok = 1'b0;
      end
      total++; if (!held_ok) begin bad++; $display("FAIL bp_hold got=v%b d%h w%b r%b exp=v1 d00 w1 r0", rsp_valid, rsp_rdata, rsp_we, req_ready); end
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=r%b v%b exp=r1 v0", req_ready, rsp_valid); end
      @(posedge clk); @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_second_accept got=%b exp=1", busy); end
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      rd = rsp_rdata; rw = rsp_we;
      total++; if (rd !== 8'h77 || rw !== 1'b0) begin bad++; $display("FAIL bp_second_rsp got=%h/%b exp=77/0", rd, rw); end
      @(posedge clk);
   endtask

   task automatic test_threshold;
      logic [7:0] rd; logic rw; int lat;
      ovr_dout[0] = 1.8;  ovr_dout[1] = 0.0;  ovr_dout[2] = 0.91; ovr_dout[3] = 0.9;
      ovr_dout[4] = 0.9;  ovr_dout[5] = 0.91; ovr_dout[6] = 0.9;  ovr_dout[7] = 0.91;
      ovr = 1'b1;
      access(1'b0, 4'h7, 8'h00, rd, rw, lat);
      ovr = 1'b0;
      total++; if (rd !== 8'hA5) begin bad++; $display("FAIL threshold got=%h exp=a5", rd); end
   endtask

   task automatic test_reset_abort;
      logic [7:0] rd; logic rw; int lat;
      logic quiet;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h3; rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      total++; if (sram_clk != 1.8) begin bad++; $display("FAIL abort_strobe got=%f exp=1.8", sram_clk); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (sram_clk != 0.0 || sram_we != 0.0 || addr_b !== 4'h0) begin bad++; $display("FAIL abort_pins got=%f/%f/%h exp=0", sram_clk, sram_we, addr_b); end
      total++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_ctrl got=r%b b%b v%b exp=r1 b0 v0", req_ready, busy, rsp_valid); end
      total++; if (rsp_rdata !== 8'h00 || rsp_we !== 1'b0) begin bad++; $display("FAIL abort_rsp got=%h/%b exp=00/0", rsp_rdata, rsp_we); end
      #1 rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid !== 1'b0) quiet = 1'b0; end
      total++; if (!quiet) begin bad++; $display("FAIL abort_no_rsp got=1 exp=0"); end
      access(1'b0, 4'h3, 8'h00, rd, rw, lat);
      total++; if (rd !== 8'h5A || lat != 4) begin bad++; $display("FAIL abort_next got=%h lat=%0d exp=5a lat=4", rd, lat); end
   endtask

   task automatic test_long;
      int lat, hi;
      logic hold_ok;
      for (int i = 0; i < 8; i++) sdout2[i] = (i % 3 == 0) ? 0.0 : 1.8;
      @(negedge clk);
      v2 = 1'b1; we2 = 1'b1; a2 = 4'h9; d2 = 8'h3C; rr2 = 1'b1;
      @(posedge clk); @(negedge clk);
      v2 = 1'b0;
      lat = 0; hi = 0; hold_ok = 1'b1;
      while (!rv2 && lat < 20) begin
         if (sclk2 > 0.9) hi++;
         if (din2_b !== 8'h3C || swe2 != 1.8) hold_ok = 1'b0;
         @(posedge clk); lat++; @(negedge clk);
      end
      total++; if (hi != 2) begin bad++; $display("FAIL long_strobe_cycles got=%0d exp=2", hi); end
      total++; if (lat != 6) begin bad++; $display("FAIL long_latency got=%0d exp=6", lat); end
      total++; if (!hold_ok) begin bad++; $display("FAIL long_din_hold got=0 exp=1"); end
      total++; if (rd2 !== 8'hB6 || rwe2 !== 1'b1) begin bad++; $display("FAIL long_rsp got=%h/%b exp=b6/1", rd2, rwe2); end
      total++; if (din2_b !== 8'h00 || sclk2 != 0.0) begin bad++; $display("FAIL long_resp_pins got=%h/%f exp=00/0.0", din2_b, sclk2); end
      @(posedge clk); @(negedge clk);
      total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL long_idle got=%b exp=1", rdy2); end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin model_dout[i] = 0.0; ovr_dout[i] = 0.0; sdout2[i] = 0.0; end
      repeat (2) @(negedge clk);
      test_reset;
      test_write_read;
      test_read_first;
      test_back_pressure;
      test_threshold;
      test_reset_abort;
      test_long;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
